// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp_pkg (package)
//  Description : Shared constants, display record type and the
//                leading-zero blanking helper for the 4-digit display scanner.
//  Revision    : 1.0  initial release
// ============================================================================
package disp_pkg;

    localparam int         DIGITS = 4;
    localparam logic [3:0] DASH   = 4'b1010;
    localparam logic [3:0] AN_OFF = 4'b1111;

    // One complete frame's worth of display content.
    typedef struct packed {
        logic [15:0] val;    // four BCD nibbles, [15:12] = digit 3
        logic [1:0]  dppos;  // digit carrying the decimal point
        logic        ovf;    // show dashes everywhere
        logic        lzb;    // leading-zero blanking enable
    } disp_rec_t;

    // Per-digit blank mask. Digit i is dark when blanking is enabled, the
    // display is not in overflow, i sits left of the decimal point and every
    // digit from the MSD down to i is zero. Digit 0 can never satisfy
    // i > dppos, so it is never blanked.
    function automatic logic [DIGITS-1:0] blank_mask(input disp_rec_t rec);
        logic [DIGITS-1:0] m;
        logic              run;
        m   = '0;
        run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run  = run & (rec.val[i*4 +: 4] == 4'd0);
            m[i] = rec.lzb & ~rec.ovf & run & (i > int'(rec.dppos));
        end
        return m;
    endfunction

endpackage : disp_pkg
`default_nettype wire

// File: rtl/disp_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : disp_scan_if (interface)
//  Description : Load port and segment/anode outputs of the display scanner.
//  Ports       : i_load  - one-cycle strobe capturing the fields below
//                i_val   - four BCD digits
//                i_dppos - decimal point digit index
//                i_ovf   - overflow (all dashes)
//                i_lzb   - leading-zero blanking enable
//                o_s     - segment decoder code (4'b1010 = dash)
//                o_dp    - decimal point, active low
//                o_an    - anode select, active-low one-hot
//  Revision    : 1.0  initial release
// ============================================================================
interface disp_scan_if;
    logic        i_load;
    logic [15:0] i_val;
    logic [1:0]  i_dppos;
    logic        i_ovf;
    logic        i_lzb;
    logic [3:0]  o_s;
    logic        o_dp;
    logic [3:0]  o_an;

    // Scanner side
    modport slave (
        input  i_load, i_val, i_dppos, i_ovf, i_lzb,
        output o_s, o_dp, o_an
    );

    // Producer of display values / consumer of the drive signals
    modport master (
        output i_load, i_val, i_dppos, i_ovf, i_lzb,
        input  o_s, o_dp, o_an
    );
endinterface : disp_scan_if
`default_nettype wire

// File: rtl/scan_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : scan_prescaler
//  Description : Slot counter running 0..REFRESH_DIV-1 with a wrap flag that
//                is high during the last cycle of each slot.
//  Ports       : clk    - system clock
//                rst_n  - asynchronous active-low reset
//                o_cnt  - current position within the slot
//                o_wrap - high while o_cnt == REFRESH_DIV-1
//  Revision    : 1.0  initial release
// ============================================================================
module scan_prescaler #(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    output logic      [CNT_W-1:0] o_cnt,
    output logic                  o_wrap
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = w_wrap;

endmodule : scan_prescaler
`default_nettype wire

// File: rtl/disp_scan.sv
`default_nettype none
// ============================================================================
//  Module      : disp_scan
//  Description : Four-digit multiplexed 7-segment scanner. Values are loaded
//                into a shadow register at any time and transferred to the
//                display register only on a frame boundary, so a frame is
//                never torn. Each digit slot begins with a guard interval of
//                dark anodes to suppress ghosting.
//  Ports       : clk   - system clock
//                rst_n - asynchronous active-low reset
//                bus   - disp_scan_if.slave (load port, S/DP/AN outputs)
//  Revision    : 1.0  initial release
// ============================================================================
module disp_scan
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 64
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    disp_scan_if.slave bus
);

    localparam int               CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] c_guard = CNT_W'(GUARD);
    localparam logic [1:0]       c_last_idx = 2'd3;

    // ------------------------------------------------------------------
    // Slot timing
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_cnt;
    logic             w_wrap;

    scan_prescaler #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_cnt  (w_cnt),
        .o_wrap (w_wrap)
    );

    logic [1:0] r_idx;
    logic       w_boundary;

    assign w_boundary = w_wrap && (r_idx == c_last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= 2'd0;
        end else if (w_wrap) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Shadow / display double buffer
    // ------------------------------------------------------------------
    disp_rec_t r_shadow;
    disp_rec_t r_disp;
    logic      r_pending;
    disp_rec_t w_load_rec;

    assign w_load_rec = '{val:   bus.i_val,
                          dppos: bus.i_dppos,
                          ovf:   bus.i_ovf,
                          lzb:   bus.i_lzb};

    // A boundary transfer samples the shadow as it stood before this cycle's
    // LOAD; a coincident LOAD therefore keeps pending set so its value is
    // shown from the following boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_disp    <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_boundary && r_pending) begin
                r_disp <= r_shadow;
            end
            if (bus.i_load) begin
                r_shadow  <= w_load_rec;
                r_pending <= 1'b1;
            end else if (w_boundary) begin
                r_pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit formatting (combinational, ahead of the output registers)
    // ------------------------------------------------------------------
    logic [DIGITS-1:0] w_blank;
    logic [3:0]        w_nib;
    logic [3:0]        w_s_nxt;
    logic              w_dp_nxt;
    logic [3:0]        w_an_nxt;

    assign w_blank = blank_mask(r_disp);
    assign w_nib   = r_disp.val[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_s_nxt  = w_nib;
        w_dp_nxt = 1'b1;
        w_an_nxt = AN_OFF;

        if (r_disp.ovf || (w_nib > 4'd9)) begin
            w_s_nxt = DASH;
        end

        if ((r_idx == r_disp.dppos) && !r_disp.ovf) begin
            w_dp_nxt = 1'b0;
        end

        // Anodes stay dark through the guard interval and for blanked digits.
        if ((w_cnt >= c_guard) && !w_blank[r_idx]) begin
            w_an_nxt = ~(4'b0001 << r_idx);
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [3:0] r_s;
    logic       r_dp;
    logic [3:0] r_an;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s  <= 4'b0000;
            r_dp <= 1'b1;
            r_an <= AN_OFF;
        end else begin
            r_s  <= w_s_nxt;
            r_dp <= w_dp_nxt;
            r_an <= w_an_nxt;
        end
    end

    assign bus.o_s  = r_s;
    assign bus.o_dp = r_dp;
    assign bus.o_an = r_an;

endmodule : disp_scan
`default_nettype wire

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: CLK cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter GUARD, default 64: cycles at the start of each slot with all anodes off (ghost suppression); legal range 1..REFRESH_DIV-2.
REQ-003 CLK  in  1  single system clock; all state is updated on its rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 LOAD  in  1  one-cycle strobe that captures VAL, DPPOS, OVF and LZB into the shadow register.
REQ-006 VAL  in  16  four BCD digits; [15:12] is digit 3 (MSD) and [3:0] is digit 0.
REQ-007 DPPOS  in  2  index of the digit that shows the decimal point.
REQ-008 OVF  in  1  overflow; when set, every digit shows a dash.
REQ-009 LZB  in  1  enables leading-zero blanking.
REQ-010 S  out  4  code to the BCD segment decoder; 0-9 are digits and 4'b1010 is a dash.
REQ-011 DP  out  1  decimal-point control to the decoder; 1 = point off, 0 = point on.
REQ-012 AN  out  4  anode select, active-low one-hot; AN[i] drives digit i.

Function
REQ-013 The slot counter shall count 0..REFRESH_DIV-1 and then wrap to 0; the digit index shall advance by one (mod 4) on each slot-counter wrap.
REQ-014 A frame shall be digit index sequence 0,1,2,3; the index wrap 3->0 is the frame boundary.
REQ-015 LOAD shall write the shadow register and set the pending flag in the same cycle, regardless of frame position.
REQ-016 At a frame boundary with pending=1, the display register shall take the shadow contents and pending shall clear, so a frame is never torn.
REQ-017 If LOAD coincides with a frame boundary, the display register shall take the pre-LOAD shadow contents and pending shall remain 1; the new value shall appear at the next boundary.
REQ-018 Repeated LOADs within one frame shall overwrite the shadow; only the last one shall be displayed.
REQ-019 S, DP and AN shall be registered, reflecting slot state with exactly one cycle of latency.
REQ-020 While the slot counter is below GUARD, AN shall be 4'b1111; otherwise AN shall be all ones except bit [idx]=0, unless that digit is blanked.
REQ-021 S for the current digit shall be its nibble; a nibble above 9 shall be replaced by 4'b1010.
REQ-022 DP shall be 0 only when idx equals the displayed DPPOS and OVF is clear.
REQ-023 With OVF=1, S shall be 4'b1010 for every digit, DP shall be 1, and no digit shall be blanked.
REQ-024 With LZB=1, digit i shall be blanked (AN[i] held at 1) when i>DPPOS and digits 3..i are all zero.
REQ-025 Digit 0 and the DPPOS digit shall never be blanked.
REQ-026 No handshake back-pressure shall exist: LOAD is always accepted.

Reset
REQ-027 While RST_N=0, the block shall hold the following values:
- slot counter = 0
- idx = 0
- pending = 0
- shadow and display registers = all fields zero
- S = 4'b0000
- DP = 1
- AN = 4'b1111
REQ-028 Reset asserted mid-frame shall discard any pending value; after release, the first slot shall start at idx 0 with a full guard interval.

Structure
REQ-029 The shared package disp_pkg shall hold DIGITS=4, DASH=4'b1010 and AN_OFF=4'b1111, plus a typedef for the display record {VAL, DPPOS, OVF, LZB}.
REQ-030 The slot counter and wrap pulse shall be a sub-module, scan_prescaler, parameterised by REFRESH_DIV.
REQ-031 Blanking, dash substitution and DP selection shall be combinational logic feeding the output registers.

Verification (REFRESH_DIV=8, GUARD=1)
REQ-032 Reset release then idle: AN=1111 for one cycle, then 1110, 1101, 1011, 0111 every 8 cycles; S=0 and DP=1 throughout.
REQ-033 LOAD VAL=16'h1234, DPPOS=2 mid-frame: display unchanged until the next 3->0 wrap, then S=4,3,2,1 with DP=0 only in slot 2.
REQ-034 LOAD VAL=16'h0050, DPPOS=0, LZB=1: AN[3] and AN[2] stay 1; digits 1 and 0 show S=5 and S=0.
REQ-035 LOAD OVF=1, VAL=16'h9999: all slots show S=1010, DP=1, and every anode is enabled in turn.
REQ-036 LOAD VAL=16'h1111, then VAL=16'h2222 in the frame-boundary cycle: the next frame shows 1111 and the frame after shows 2222.
REQ-037 LOAD VAL=16'h00C0: digit 1 shows S=1010; RST_N pulsed low mid-frame forces AN=1111, S=0 and DP=1 immediately.
